// File: rtl/ydma_hls_deadlock_report_unit_if.sv
// Signal bundle between the deadlock report unit, the per-process detect units and the host.
// The slave modport is the report unit itself; master is the environment driving it.
interface ydma_hls_deadlock_report_unit_if #(
    parameter int PROC_NUM = 4,
    parameter int CHAN_NUM = 6,
    parameter int MAX_HOPS = 255
);
    localparam int ID_W  = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
    localparam int HOP_W = $clog2(MAX_HOPS + 1);

    logic [PROC_NUM-1:0] dl_detect_vec;
    logic [CHAN_NUM-1:0] token_vec;
    logic                report_clear;
    logic                dl_detect_bcast;
    logic [PROC_NUM-1:0] origin_vec;
    logic [PROC_NUM-1:0] token_clear_vec;
    logic                report_valid;
    logic [ID_W-1:0]     origin_id;
    logic [CHAN_NUM-1:0] chan_trace;
    logic [HOP_W-1:0]    hop_cnt;
    logic                overflow;

    modport master (
        output dl_detect_vec, token_vec, report_clear,
        input  dl_detect_bcast, origin_vec, token_clear_vec, report_valid,
               origin_id, chan_trace, hop_cnt, overflow
    );

    modport slave (
        input  dl_detect_vec, token_vec, report_clear,
        output dl_detect_bcast, origin_vec, token_clear_vec, report_valid,
               origin_id, chan_trace, hop_cnt, overflow
    );
endinterface

// File: rtl/ydma_hls_deadlock_report_unit.sv
// Picks the lowest flagging process, traces its token around the dependence loop and holds a
// report of the visited channels until the host acknowledges it.
//
// state  | meaning
// IDLE   | waiting for any detect unit to flag
// ORIGIN | one-cycle origin pulse to the chosen process, trace registers cleared
// TRACE  | accumulating live tokens until loop close, false alarm or hop limit
// DONE   | report held until report_clear
module ydma_hls_deadlock_report_unit #(
    parameter int PROC_NUM = 4,
    parameter int CHAN_NUM = 6,
    parameter int MAX_HOPS = 255
) (
    input logic clock,
    input logic reset,
    ydma_hls_deadlock_report_unit_if.slave bus
);
    localparam int ID_W  = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
    localparam int HOP_W = $clog2(MAX_HOPS + 1);
    localparam logic [HOP_W-1:0] HOP_MAX = HOP_W'(MAX_HOPS);

    typedef enum logic [1:0] {IDLE, ORIGIN, TRACE, DONE} state_t;

    state_t              state;
    logic [ID_W-1:0]     origin_id;
    logic [PROC_NUM-1:0] origin_vec;
    logic [CHAN_NUM-1:0] chan_trace;
    logic [HOP_W-1:0]    hop_cnt;
    logic                dl_detect_bcast;
    logic                report_valid;
    logic                overflow;

    logic [ID_W-1:0]     low_idx;
    logic [PROC_NUM-1:0] low_hot;
    logic [PROC_NUM-1:0] token_clear;
    logic [HOP_W-1:0]    hop_inc;
    logic                loop_close;

    // Descending scan so the lowest set index wins.
    always_comb begin
        low_idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (bus.dl_detect_vec[i]) low_idx = ID_W'(i);
        end
        low_hot = '0;
        low_hot[low_idx] = 1'b1;
    end

    assign loop_close = (state == TRACE) && bus.dl_detect_vec[origin_id];
    assign hop_inc    = (hop_cnt == HOP_MAX) ? hop_cnt : hop_cnt + HOP_W'(1);

    always_comb begin
        token_clear = '0;
        if (loop_close) token_clear[origin_id] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            origin_id       <= '0;
            origin_vec      <= '0;
            chan_trace      <= '0;
            hop_cnt         <= '0;
            dl_detect_bcast <= 1'b0;
            report_valid    <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.dl_detect_vec) begin
                        origin_id       <= low_idx;
                        origin_vec      <= low_hot;
                        dl_detect_bcast <= 1'b1;
                        state           <= ORIGIN;
                    end
                end
                ORIGIN: begin
                    origin_vec <= '0;
                    chan_trace <= '0;
                    hop_cnt    <= '0;
                    state      <= TRACE;
                end
                TRACE: begin
                    // Close beats timeout beats false alarm; a false alarm freezes the trace.
                    if (loop_close || hop_inc == HOP_MAX) begin
                        chan_trace   <= chan_trace | bus.token_vec;
                        hop_cnt      <= hop_inc;
                        overflow     <= !loop_close;
                        report_valid <= 1'b1;
                        state        <= DONE;
                    end else if (bus.token_vec == '0 && hop_cnt != '0) begin
                        dl_detect_bcast <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        chan_trace <= chan_trace | bus.token_vec;
                        hop_cnt    <= hop_inc;
                    end
                end
                DONE: begin
                    if (bus.report_clear) begin
                        report_valid    <= 1'b0;
                        overflow        <= 1'b0;
                        dl_detect_bcast <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dl_detect_bcast = dl_detect_bcast;
    assign bus.origin_vec      = origin_vec;
    assign bus.token_clear_vec = token_clear;
    assign bus.report_valid    = report_valid;
    assign bus.origin_id       = origin_id;
    assign bus.chan_trace      = chan_trace;
    assign bus.hop_cnt         = hop_cnt;
    assign bus.overflow        = overflow;
endmodule

// File: tb/tb_ydma_hls_deadlock_report_unit.sv
// Bench for the deadlock report unit: directed scenarios on a default and a MAX_HOPS=3 instance,
// then randomized episodes scored against an episode-level reference model.
module tb_ydma_hls_deadlock_report_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    ydma_hls_deadlock_report_unit_if #(.PROC_NUM(4), .CHAN_NUM(6), .MAX_HOPS(255)) ifa ();
    ydma_hls_deadlock_report_unit_if #(.PROC_NUM(4), .CHAN_NUM(6), .MAX_HOPS(3))   ifb ();

    ydma_hls_deadlock_report_unit #(.PROC_NUM(4), .CHAN_NUM(6), .MAX_HOPS(255)) dut_a (
        .clock(clock), .reset(reset), .bus(ifa.slave));
    ydma_hls_deadlock_report_unit #(.PROC_NUM(4), .CHAN_NUM(6), .MAX_HOPS(3)) dut_b (
        .clock(clock), .reset(reset), .bus(ifb.slave));

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic clear_inputs();
        ifa.dl_detect_vec = '0; ifa.token_vec = '0; ifa.report_clear = 1'b0;
        ifb.dl_detect_vec = '0; ifb.token_vec = '0; ifb.report_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({ifa.dl_detect_bcast, ifa.origin_vec, ifa.token_clear_vec, ifa.report_valid, ifa.origin_id,
             ifa.chan_trace, ifa.hop_cnt, ifa.overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_a got bcast=%b ov=%b tc=%b rv=%b id=%0d ct=%b hop=%0d ovf=%b required all 0",
                     ifa.dl_detect_bcast, ifa.origin_vec, ifa.token_clear_vec, ifa.report_valid,
                     ifa.origin_id, ifa.chan_trace, ifa.hop_cnt, ifa.overflow);
        end
        n_cmp++;
        if ({ifb.dl_detect_bcast, ifb.report_valid, ifb.overflow, ifb.hop_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_b got bcast=%b rv=%b ovf=%b hop=%0d required 0",
                     ifb.dl_detect_bcast, ifb.report_valid, ifb.overflow, ifb.hop_cnt);
        end
        ifa.dl_detect_vec = 4'b0010;
        @(negedge clock);
        n_cmp++;
        if (ifa.origin_vec !== 4'b0000 || ifa.dl_detect_bcast !== 1'b0) begin
            n_err++;
            $display("FAIL held_in_reset got ov=%b bcast=%b required 0000/0", ifa.origin_vec, ifa.dl_detect_bcast);
        end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (ifa.origin_vec !== 4'b0010 || ifa.origin_id !== 2'd1 || ifa.dl_detect_bcast !== 1'b1) begin
            n_err++;
            $display("FAIL first_edge_detect got ov=%b id=%0d bcast=%b required 0010/1/1",
                     ifa.origin_vec, ifa.origin_id, ifa.dl_detect_bcast);
        end
        do_reset();
    endtask

    task automatic test_origin_and_close();
        ifa.dl_detect_vec = 4'b0100;
        @(negedge clock);
        n_cmp++;
        if (ifa.origin_id !== 2'd2 || ifa.origin_vec !== 4'b0100 || ifa.dl_detect_bcast !== 1'b1) begin
            n_err++;
            $display("FAIL origin_pulse got id=%0d ov=%b bcast=%b required 2/0100/1",
                     ifa.origin_id, ifa.origin_vec, ifa.dl_detect_bcast);
        end
        ifa.dl_detect_vec = 4'b0000;
        @(negedge clock);
        n_cmp++;
        if (ifa.origin_vec !== 4'b0000 || ifa.dl_detect_bcast !== 1'b1 || ifa.hop_cnt !== 8'd0 ||
            ifa.chan_trace !== 6'b0) begin
            n_err++;
            $display("FAIL trace_entry got ov=%b bcast=%b hop=%0d ct=%b required 0000/1/0/000000",
                     ifa.origin_vec, ifa.dl_detect_bcast, ifa.hop_cnt, ifa.chan_trace);
        end
        ifa.token_vec = 6'b000001;
        @(negedge clock);
        ifa.token_vec = 6'b000100;
        @(negedge clock);
        ifa.token_vec = 6'b000000;
        ifa.dl_detect_vec = 4'b0100;
        #1;
        n_cmp++;
        if (ifa.token_clear_vec !== 4'b0100) begin
            n_err++;
            $display("FAIL close_token_clear got %b required 0100", ifa.token_clear_vec);
        end
        @(negedge clock);
        n_cmp++;
        if (ifa.report_valid !== 1'b1 || ifa.chan_trace !== 6'b000101 || ifa.hop_cnt !== 8'd3 ||
            ifa.overflow !== 1'b0 || ifa.token_clear_vec !== 4'b0000) begin
            n_err++;
            $display("FAIL close_report got rv=%b ct=%b hop=%0d ovf=%b tc=%b required 1/000101/3/0/0000",
                     ifa.report_valid, ifa.chan_trace, ifa.hop_cnt, ifa.overflow, ifa.token_clear_vec);
        end
        for (int i = 0; i < 2; i++) begin
            ifa.dl_detect_vec = 4'b1111;
            ifa.token_vec = 6'h3f;
            @(negedge clock);
            n_cmp++;
            if (ifa.report_valid !== 1'b1 || ifa.chan_trace !== 6'b000101 || ifa.hop_cnt !== 8'd3 ||
                ifa.origin_id !== 2'd2 || ifa.token_clear_vec !== 4'b0000 || ifa.origin_vec !== 4'b0000) begin
                n_err++;
                $display("FAIL done_hold got rv=%b ct=%b hop=%0d id=%0d tc=%b ov=%b required 1/000101/3/2/0000/0000",
                         ifa.report_valid, ifa.chan_trace, ifa.hop_cnt, ifa.origin_id,
                         ifa.token_clear_vec, ifa.origin_vec);
            end
        end
        ifa.dl_detect_vec = '0;
        ifa.token_vec = '0;
        ifa.report_clear = 1'b1;
        @(negedge clock);
        ifa.report_clear = 1'b0;
        n_cmp++;
        if (ifa.report_valid !== 1'b0 || ifa.dl_detect_bcast !== 1'b0 || ifa.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL report_clear got rv=%b bcast=%b ovf=%b required 0/0/0",
                     ifa.report_valid, ifa.dl_detect_bcast, ifa.overflow);
        end
    endtask

    task automatic test_multi_detect();
        do_reset();
        ifa.dl_detect_vec = 4'b1010;
        @(negedge clock);
        n_cmp++;
        if (ifa.origin_id !== 2'd1 || ifa.origin_vec !== 4'b0010) begin
            n_err++;
            $display("FAIL multi_origin got id=%0d ov=%b required 1/0010", ifa.origin_id, ifa.origin_vec);
        end
        ifa.dl_detect_vec = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            ifa.token_vec = 6'b010000;
            @(negedge clock);
            n_cmp++;
            if (ifa.origin_vec !== 4'b0000 || ifa.token_clear_vec !== 4'b0000) begin
                n_err++;
                $display("FAIL multi_no_second_pulse got ov=%b tc=%b required 0000/0000",
                         ifa.origin_vec, ifa.token_clear_vec);
            end
        end
        ifa.dl_detect_vec = 4'b0010;
        @(negedge clock);
        ifa.dl_detect_vec = '0;
        ifa.token_vec = '0;
        n_cmp++;
        if (ifa.report_valid !== 1'b1 || ifa.origin_id !== 2'd1 || ifa.hop_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL multi_close got rv=%b id=%0d hop=%0d required 1/1/3",
                     ifa.report_valid, ifa.origin_id, ifa.hop_cnt);
        end
    endtask

    task automatic test_false_alarm();
        do_reset();
        ifa.dl_detect_vec = 4'b0001;
        @(negedge clock);
        ifa.dl_detect_vec = 4'b0000;
        ifa.token_vec = 6'b000010;
        @(negedge clock);
        @(negedge clock);
        ifa.token_vec = 6'b000000;
        @(negedge clock);
        n_cmp++;
        if (ifa.report_valid !== 1'b0 || ifa.dl_detect_bcast !== 1'b0 || ifa.chan_trace !== 6'b000010 ||
            ifa.hop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL false_alarm got rv=%b bcast=%b ct=%b hop=%0d required 0/0/000010/1",
                     ifa.report_valid, ifa.dl_detect_bcast, ifa.chan_trace, ifa.hop_cnt);
        end
        ifa.dl_detect_vec = 4'b0100;
        @(negedge clock);
        ifa.dl_detect_vec = 4'b0000;
        n_cmp++;
        if (ifa.origin_vec !== 4'b0100 || ifa.origin_id !== 2'd2) begin
            n_err++;
            $display("FAIL rearm_after_false got ov=%b id=%0d required 0100/2", ifa.origin_vec, ifa.origin_id);
        end
    endtask

    task automatic test_timeout();
        logic [5:0] exp_chan;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            exp_chan = '0;
            ifb.dl_detect_vec = 4'b0001;
            @(negedge clock);
            ifb.dl_detect_vec = 4'b0000;
            @(negedge clock);
            for (int c = 0; c < 3; c++) begin
                ifb.token_vec = 6'($urandom_range(1, 63));
                exp_chan |= ifb.token_vec;
                if (c == 2 && pass == 1) ifb.dl_detect_vec = 4'b0001;
                @(negedge clock);
            end
            ifb.dl_detect_vec = '0;
            ifb.token_vec = '0;
            n_cmp++;
            if (ifb.report_valid !== 1'b1 || ifb.overflow !== (pass == 0) || ifb.hop_cnt !== 2'd3 ||
                ifb.chan_trace !== exp_chan) begin
                n_err++;
                $display("FAIL timeout_pass%0d got rv=%b ovf=%b hop=%0d ct=%b required 1/%0d/3/%b",
                         pass, ifb.report_valid, ifb.overflow, ifb.hop_cnt, ifb.chan_trace,
                         (pass == 0), exp_chan);
            end
            ifb.report_clear = 1'b1;
            @(negedge clock);
            ifb.report_clear = 1'b0;
            n_cmp++;
            if (ifb.report_valid !== 1'b0 || ifb.overflow !== 1'b0 || ifb.dl_detect_bcast !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_clear got rv=%b ovf=%b bcast=%b required 0/0/0",
                         ifb.report_valid, ifb.overflow, ifb.dl_detect_bcast);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ifa.dl_detect_vec = 4'b0001;
        @(negedge clock);
        ifa.dl_detect_vec = 4'b0000;
        @(negedge clock);
        ifa.token_vec = 6'b100000;
        @(negedge clock);
        ifa.token_vec = 6'b001000;
        ifa.dl_detect_vec = 4'b0001;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.dl_detect_bcast, ifa.origin_vec, ifa.token_clear_vec, ifa.report_valid, ifa.origin_id,
             ifa.chan_trace, ifa.hop_cnt, ifa.overflow} !== '0) begin
            n_err++;
            $display("FAIL async_reset got bcast=%b tc=%b ct=%b hop=%0d required all 0",
                     ifa.dl_detect_bcast, ifa.token_clear_vec, ifa.chan_trace, ifa.hop_cnt);
        end
        ifa.dl_detect_vec = '0;
        ifa.token_vec = '0;
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (ifa.dl_detect_bcast !== 1'b0 || ifa.report_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle got bcast=%b rv=%b required 0/0", ifa.dl_detect_bcast, ifa.report_valid);
        end
        ifa.dl_detect_vec = 4'b1000;
        @(negedge clock);
        ifa.dl_detect_vec = '0;
        n_cmp++;
        if (ifa.origin_vec !== 4'b1000 || ifa.origin_id !== 2'd3) begin
            n_err++;
            $display("FAIL post_reset_detect got ov=%b id=%0d required 1000/3", ifa.origin_vec, ifa.origin_id);
        end
        do_reset();
    endtask

    // Episode model: origin = lowest flag, trace = OR of counted tokens, hop = counted cycles.
    task automatic test_random();
        logic [3:0] det, o_hot, junk;
        logic [5:0] exp_chan;
        int         o, k, mode;
        for (int ep = 0; ep < 40; ep++) begin
            det = 4'($urandom_range(1, 15));
            o = lowest(det);
            o_hot = 4'b0001 << o;
            ifa.dl_detect_vec = det;
            @(negedge clock);
            n_cmp++;
            if (ifa.origin_id !== 2'(o) || ifa.origin_vec !== o_hot) begin
                n_err++;
                $display("FAIL rand_origin ep=%0d got id=%0d ov=%b required %0d/%b",
                         ep, ifa.origin_id, ifa.origin_vec, o, o_hot);
            end
            ifa.dl_detect_vec = 4'($urandom) & ~o_hot;
            ifa.token_vec = 6'($urandom);
            @(negedge clock);
            exp_chan = '0;
            k = $urandom_range(1, 5);
            for (int i = 0; i < k; i++) begin
                ifa.token_vec = (i == 0) ? 6'($urandom) : 6'($urandom_range(1, 63));
                ifa.dl_detect_vec = 4'($urandom) & ~o_hot;
                exp_chan |= ifa.token_vec;
                @(negedge clock);
            end
            mode = $urandom_range(0, 1);
            junk = 4'($urandom);
            if (mode == 0) begin
                ifa.token_vec = 6'($urandom);
                ifa.dl_detect_vec = junk | o_hot;
                exp_chan |= ifa.token_vec;
            end else begin
                ifa.token_vec = '0;
                ifa.dl_detect_vec = junk & ~o_hot;
            end
            #1;
            n_cmp++;
            if (ifa.token_clear_vec !== ((mode == 0) ? o_hot : 4'b0000)) begin
                n_err++;
                $display("FAIL rand_token_clear ep=%0d got %b required %b",
                         ep, ifa.token_clear_vec, (mode == 0) ? o_hot : 4'b0000);
            end
            @(negedge clock);
            n_cmp++;
            if (ifa.report_valid !== (mode == 0) || ifa.dl_detect_bcast !== (mode == 0) ||
                ifa.chan_trace !== exp_chan || ifa.hop_cnt !== 8'((mode == 0) ? k + 1 : k) ||
                ifa.overflow !== 1'b0) begin
                n_err++;
                $display("FAIL rand_result ep=%0d mode=%0d got rv=%b bcast=%b ct=%b hop=%0d ovf=%b required ct=%b hop=%0d",
                         ep, mode, ifa.report_valid, ifa.dl_detect_bcast, ifa.chan_trace, ifa.hop_cnt,
                         ifa.overflow, exp_chan, (mode == 0) ? k + 1 : k);
            end
            if (mode == 0) begin
                repeat ($urandom_range(0, 2)) begin
                    ifa.dl_detect_vec = 4'($urandom);
                    ifa.token_vec = 6'($urandom);
                    @(negedge clock);
                end
                ifa.report_clear = 1'b1;
                @(negedge clock);
                ifa.report_clear = 1'b0;
                n_cmp++;
                if (ifa.report_valid !== 1'b0 || ifa.dl_detect_bcast !== 1'b0 ||
                    ifa.chan_trace !== exp_chan || ifa.origin_id !== 2'(o)) begin
                    n_err++;
                    $display("FAIL rand_clear ep=%0d got rv=%b bcast=%b ct=%b id=%0d required 0/0/%b/%0d",
                             ep, ifa.report_valid, ifa.dl_detect_bcast, ifa.chan_trace, ifa.origin_id,
                             exp_chan, o);
                end
            end
            ifa.dl_detect_vec = '0;
            ifa.token_vec = '0;
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        test_reset();
        test_origin_and_close();
        test_multi_detect();
        test_false_alarm();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ydma_hls_deadlock_report_unit.md
YDMA_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: ydma_hls_deadlock_report_unit

Interface
REQ-001 Parameter PROC_NUM, default 4, is the number of per-process detect units served.
REQ-002 Parameter CHAN_NUM, default 6, is the total dependence channels; token_vec is the concatenation of all units' token_out_vec.
REQ-003 Parameter MAX_HOPS, default 255, is the TRACE cycle limit; HOP_W = clog2(MAX_HOPS+1).
REQ-004 Port clock, input, 1, is the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, is the asynchronous active-low reset.
REQ-006 Port dl_detect_vec, input, PROC_NUM, carries the dl_detect_out of each unit.
REQ-007 Port token_vec, input, CHAN_NUM, carries the live tokens from all units.
REQ-008 Port report_clear, input, 1, is a one-cycle host acknowledge of a report.
REQ-009 Port dl_detect_bcast, output, 1, is the dl_detect_in broadcast to all units.
REQ-010 Port origin_vec, output, PROC_NUM, drives the one-hot origin pulse per unit.
REQ-011 Port token_clear_vec, output, PROC_NUM, drives the token_clear of each unit.
REQ-012 Port report_valid, output, 1, means a report is held.
REQ-013 Port origin_id, output, clog2(PROC_NUM) (min 1), is the index of the origin process.
REQ-014 Port chan_trace, output, CHAN_NUM, marks the channels the token traversed.
REQ-015 Port hop_cnt, output, HOP_W, is the number of TRACE cycles.
REQ-016 Port overflow, output, 1, means TRACE hit MAX_HOPS without the loop closing.

Function
REQ-017 The FSM SHALL have states IDLE, ORIGIN, TRACE and DONE, one-state-per-cycle registered.
REQ-018 In IDLE, when |dl_detect_vec is 1, the block SHALL register origin_id as the lowest set index and go to ORIGIN; otherwise it stays in IDLE.
REQ-019 In ORIGIN (exactly one cycle), origin_vec SHALL equal 1<<origin_id, chan_trace and hop_cnt SHALL clear, and the FSM SHALL go to TRACE.
REQ-020 origin_vec SHALL be 0 in every state other than ORIGIN.
REQ-021 dl_detect_bcast SHALL be 1 in ORIGIN, TRACE and DONE, and 0 in IDLE.
REQ-022 In TRACE, each cycle SHALL perform chan_trace <= chan_trace | token_vec and hop_cnt <= hop_cnt+1, saturating at MAX_HOPS.
REQ-023 Loop close: in TRACE, when dl_detect_vec[origin_id]=1, token_clear_vec SHALL be combinationally 1<<origin_id in that same cycle; the FSM SHALL go to DONE with overflow=0.
REQ-024 token_clear_vec SHALL be 0 in every other case.
REQ-025 False alarm: in TRACE, when token_vec=0 and hop_cnt>=1 and the loop has not closed, the FSM SHALL return to IDLE, report_valid stays 0, and chan_trace and hop_cnt hold their last values.
REQ-026 Timeout: in TRACE, when hop_cnt=MAX_HOPS and the loop has not closed, the FSM SHALL go to DONE with overflow=1.
REQ-027 Loop close SHALL take priority over timeout in the same cycle; timeout SHALL take priority over false alarm.
REQ-028 In DONE, report_valid SHALL be 1, and origin_id, chan_trace, hop_cnt and overflow SHALL hold.
REQ-029 In DONE, dl_detect_vec and token_vec SHALL be ignored.
REQ-030 In DONE, report_clear=1 SHALL return the FSM to IDLE on the next edge and clear report_valid and overflow.
REQ-031 report_clear in any state other than DONE SHALL have no effect.
REQ-032 When multiple bits of dl_detect_vec are set in IDLE, only the lowest index SHALL be used; the others are ignored until IDLE is re-entered.

Reset
REQ-033 With reset=0, the block SHALL asynchronously force state=IDLE and all outputs and registers to 0.
REQ-034 Reset asserted in mid TRACE or DONE SHALL abort the operation with no report retained.
REQ-035 The first detection after reset release SHALL be evaluated on the first rising clock edge.

Verification
REQ-036 Bench SHALL cover: PROC_NUM=4; dl_detect_vec=4'b0100 in IDLE -> origin_id=2, origin_vec=4'b0100 for exactly 1 cycle, dl_detect_bcast=1 from the next cycle on.
REQ-037 Bench SHALL cover: token_vec sequence 6'b000001, then 6'b000100, then dl_detect_vec[2]=1 -> token_clear_vec=4'b0100 that cycle, report_valid=1 next cycle, chan_trace=6'b000101, hop_cnt=3, overflow=0.
REQ-038 Bench SHALL cover: dl_detect_vec=4'b1010 -> origin_id=1; the simultaneous bit 3 produces no second origin pulse.
REQ-039 Bench SHALL cover: TRACE with token_vec=0 in the second cycle -> return to IDLE, report_valid=0, dl_detect_bcast=0.
REQ-040 Bench SHALL cover: MAX_HOPS=3 with tokens never returning -> DONE after 3 TRACE cycles, overflow=1, hop_cnt=3; report_clear -> IDLE, overflow=0.
REQ-041 Bench SHALL cover: reset pulsed low mid-TRACE, asynchronous to clock -> all outputs 0 immediately, and after release the FSM is IDLE.
